// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Purpose  : Multicycle ALU with start/done handshake. Single-cycle add,
//             sub, and, or, xor and clear; iterative one-bit-per-cycle
//             shifter; signed shift-add multiplier. Result and flags are
//             registered and hold from done until the next op completes.
//  Revision : 1.0  initial release
//
//  Ports
//    clk       in   rising-edge clock
//    rst       in   synchronous active-high reset
//    start_i   in   request, accepted when not busy
//    op_i      in   [2:0] 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 clear,
//                         6 shift, 7 signed multiply
//    a_i, b_i  in   [W-1:0] operands
//    busy_o    out  operation in progress
//    done_o    out  one-cycle completion pulse
//    result_o  out  [2W-1:0] result (W-bit ops are zero-extended)
//    co_o      out  carry / last bit shifted out
//    ovf_o     out  signed overflow (or unsupported op)
//    z_o       out  zero
//    n_o       out  negative (true sign)
//
//  Build option
//    SEQ_ALU_MUL_EN  defined: op 7 is the signed multiplier.
//                    undefined: op 7 completes in one cycle with result 0,
//                    z=1, ovf=1 to flag the unsupported operation.
// ============================================================================
module seq_alu #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic [2:0]     op_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*W-1:0] result_o,
    output logic           co_o,
    output logic           ovf_o,
    output logic           z_o,
    output logic           n_o
);

    localparam int LG = $clog2(W);
    localparam int CW = LG + 1;           // counter must hold W for multiply
`ifdef SEQ_ALU_MUL_EN
    localparam int AW = 2 * W;            // accumulator doubles as product
`else
    localparam int AW = W;
`endif

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_OR  = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_CLR = 3'd5;
    localparam logic [2:0] c_OP_SHF = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic             dir_q, dir_d;
    logic [2*W-1:0]   result_q, result_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;
    logic             z_q, z_d;
    logic             n_q, n_d;
`ifdef SEQ_ALU_MUL_EN
    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic             sign_q, sign_d;
    logic             is_mul_q, is_mul_d;
`endif

    // ---------------- single-cycle datapath (operates on live inputs) -------
    // Ops 0-5 complete on the accepting edge, so they read the operands
    // directly; that edge is also the one that latches them.
    logic [W-1:0] w_bop;
    logic [W:0]   w_sum;
    logic         w_add_ovf;
    logic [W-1:0] w_logic;

    assign w_bop     = op_i[0] ? ~b_i : b_i;
    assign w_sum     = {1'b0, a_i} + {1'b0, w_bop} + {{W{1'b0}}, op_i[0]};
    assign w_add_ovf = (a_i[W-1] == w_bop[W-1]) && (w_sum[W-1] != a_i[W-1]);

    always_comb begin
        w_logic = '0;
        case (op_i)
            c_OP_AND: w_logic = a_i & b_i;
            c_OP_OR:  w_logic = a_i | b_i;
            c_OP_XOR: w_logic = a_i ^ b_i;
            default:  w_logic = '0;
        endcase
    end

    // ---------------- iterative shifter -------------------------------------
    logic [W-1:0] w_sh_cur;
    logic [W-1:0] w_sh_nxt;
    logic         w_sh_out;

    assign w_sh_cur = acc_q[W-1:0];
    assign w_sh_out = dir_q ? w_sh_cur[0] : w_sh_cur[W-1];
    assign w_sh_nxt = dir_q ? {1'b0, w_sh_cur[W-1:1]} : {w_sh_cur[W-2:0], 1'b0};

`ifdef SEQ_ALU_MUL_EN
    // ---------------- shift-add multiplier ----------------------------------
    logic [W-1:0]   w_mag_a;
    logic [W-1:0]   w_mag_b;
    logic [2*W-1:0] w_mul_sum;
    logic [2*W-1:0] w_mul_fin;
    logic           w_mul_ovf;

    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude in W bits.
    assign w_mag_a   = a_i[W-1] ? ({W{1'b0}} - a_i) : a_i;
    assign w_mag_b   = b_i[W-1] ? ({W{1'b0}} - b_i) : b_i;
    assign w_mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign w_mul_fin = (sign_q && (|w_mul_sum)) ? ({(2*W){1'b0}} - w_mul_sum)
                                                : w_mul_sum;
    // Fits in W signed bits only if the upper W+1 bits are a pure sign run.
    assign w_mul_ovf = !((&w_mul_fin[2*W-1:W-1]) || !(|w_mul_fin[2*W-1:W-1]));
`endif

    // ---------------- next-state logic --------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        dir_d    = dir_q;
        result_d = result_q;
        co_d     = co_q;
        ovf_d    = ovf_q;
        z_d      = z_q;
        n_d      = n_q;
`ifdef SEQ_ALU_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        is_mul_d = is_mul_q;
`endif

        case (state_q)
            S_RUN: begin
                cnt_d = cnt_q - 1'b1;
`ifdef SEQ_ALU_MUL_EN
                if (is_mul_q) begin
                    acc_d    = w_mul_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (cnt_q == CW'(1)) begin
                        state_d  = S_DONE;
                        result_d = w_mul_fin;
                        co_d     = 1'b0;
                        ovf_d    = w_mul_ovf;
                        z_d      = ~|w_mul_fin;
                        n_d      = w_mul_fin[2*W-1];
                    end
                end else
`endif
                begin
                    acc_d[W-1:0] = w_sh_nxt;
                    // Flags stay frozen until the final step so the previous
                    // op's results remain visible while busy.
                    if (cnt_q == CW'(1)) begin
                        state_d  = S_DONE;
                        result_d = {{W{1'b0}}, w_sh_nxt};
                        co_d     = w_sh_out;
                        ovf_d    = 1'b0;
                        z_d      = ~|w_sh_nxt;
                        n_d      = w_sh_nxt[W-1];
                    end
                end
            end

            default: begin  // S_IDLE and S_DONE both accept a new request
                if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
                if (start_i) begin
                    state_d = S_DONE;
                    case (op_i)
                        c_OP_ADD, c_OP_SUB: begin
                            result_d = {{W{1'b0}}, w_sum[W-1:0]};
                            co_d     = w_sum[W];
                            ovf_d    = w_add_ovf;
                            z_d      = ~|w_sum[W-1:0];
                            n_d      = w_sum[W-1] ^ w_add_ovf;
                        end
                        c_OP_AND, c_OP_OR, c_OP_XOR, c_OP_CLR: begin
                            result_d = {{W{1'b0}}, w_logic};
                            co_d     = 1'b0;
                            ovf_d    = 1'b0;
                            z_d      = ~|w_logic;
                            n_d      = w_logic[W-1];
                        end
                        c_OP_SHF: begin
                            if (b_i[LG-1:0] == '0) begin
                                // Zero-length shift bypasses RUN entirely.
                                result_d = {{W{1'b0}}, a_i};
                                co_d     = 1'b0;
                                ovf_d    = 1'b0;
                                z_d      = ~|a_i;
                                n_d      = a_i[W-1];
                            end else begin
                                state_d  = S_RUN;
                                cnt_d    = {1'b0, b_i[LG-1:0]};
                                acc_d    = AW'(a_i);
                                dir_d    = b_i[W-1];
`ifdef SEQ_ALU_MUL_EN
                                is_mul_d = 1'b0;
`endif
                            end
                        end
                        default: begin  // op 7
`ifdef SEQ_ALU_MUL_EN
                            state_d  = S_RUN;
                            cnt_d    = CW'(W);
                            acc_d    = '0;
                            mcand_d  = {{W{1'b0}}, w_mag_a};
                            mplier_d = w_mag_b;
                            sign_d   = a_i[W-1] ^ b_i[W-1];
                            is_mul_d = 1'b1;
`else
                            result_d = '0;
                            co_d     = 1'b0;
                            ovf_d    = 1'b1;
                            z_d      = 1'b1;
                            n_d      = 1'b0;
`endif
                        end
                    endcase
                end
            end
        endcase
    end

    // ---------------- state register ----------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            dir_q    <= 1'b0;
            result_q <= '0;
            co_q     <= 1'b0;
            ovf_q    <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            is_mul_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            dir_q    <= dir_d;
            result_q <= result_d;
            co_q     <= co_d;
            ovf_q    <= ovf_d;
            z_q      <= z_d;
            n_q      <= n_d;
`ifdef SEQ_ALU_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sign_q   <= sign_d;
            is_mul_q <= is_mul_d;
`endif
        end
    end

    assign busy_o   = (state_q == S_RUN);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;
    assign co_o     = co_q;
    assign ovf_o    = ovf_q;
    assign z_o      = z_q;
    assign n_o      = n_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_alu
//  Purpose  : Self-checking bench for seq_alu (W=8). Table of directed
//             vectors plus hand-written sequences for start-while-busy,
//             back-to-back acceptance in DONE and reset mid-multiply.
//             Multiply expectations follow SEQ_ALU_MUL_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_alu;

    localparam int W  = 8;
    localparam int NV = 19;
`ifdef SEQ_ALU_MUL_EN
    localparam int          MUL_LAT = 9;
    localparam logic [15:0] MUL_RES = 16'hFFF1;
`else
    localparam int          MUL_LAT = 1;
    localparam logic [15:0] MUL_RES = 16'h0000;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           co;
    logic           ovf;
    logic           z;
    logic           n;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        int          lat;
        logic [15:0] res;
        logic [3:0]  flags;   // {co, ovf, z, n}
    } vec_t;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    seq_alu #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .op_i     (op),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result),
        .co_o     (co),
        .ovf_o    (ovf),
        .z_o      (z),
        .n_o      (n)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one op, scramble the inputs after acceptance, and measure the
    // latency: 1 means done is high in the cycle right after the accepting edge.
    task automatic run_op(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                          output int lat);
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd3; a = 8'h5A; b = 8'hC3;
        lat = 1;
        while (!done && lat < 40) begin
            check("busy_while_waiting", {31'b0, busy}, 32'd1);
            @(posedge clk); #1;
            lat++;
        end
        check("busy_low_at_done", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int dcount;

        vecs[0]  = '{3'd0, 8'h7F, 8'h01, 1, 16'h0080, 4'b0100};
        vecs[1]  = '{3'd1, 8'h00, 8'h01, 1, 16'h00FF, 4'b0001};
        vecs[2]  = '{3'd5, 8'h55, 8'hAA, 1, 16'h0000, 4'b0010};
        vecs[3]  = '{3'd0, 8'hFF, 8'h01, 1, 16'h0000, 4'b1010};
        vecs[4]  = '{3'd1, 8'h80, 8'h01, 1, 16'h007F, 4'b1101};
        vecs[5]  = '{3'd2, 8'hF0, 8'h3C, 1, 16'h0030, 4'b0000};
        vecs[6]  = '{3'd3, 8'h80, 8'h01, 1, 16'h0081, 4'b0001};
        vecs[7]  = '{3'd4, 8'hA5, 8'hA5, 1, 16'h0000, 4'b0010};
        vecs[8]  = '{3'd6, 8'h81, 8'h03, 4, 16'h0008, 4'b0000};
        vecs[9]  = '{3'd6, 8'h81, 8'h83, 4, 16'h0010, 4'b0000};
        vecs[10] = '{3'd6, 8'h81, 8'h00, 1, 16'h0081, 4'b0001};
        vecs[11] = '{3'd6, 8'hC0, 8'h01, 2, 16'h0080, 4'b1001};
        vecs[12] = '{3'd6, 8'h01, 8'h81, 2, 16'h0000, 4'b1010};
`ifdef SEQ_ALU_MUL_EN
        vecs[13] = '{3'd7, 8'hFD, 8'h05, 9, 16'hFFF1, 4'b0001};
        vecs[14] = '{3'd7, 8'h80, 8'h80, 9, 16'h4000, 4'b0100};
        vecs[15] = '{3'd7, 8'h7F, 8'h7F, 9, 16'h3F01, 4'b0100};
        vecs[16] = '{3'd7, 8'h00, 8'h85, 9, 16'h0000, 4'b0010};
        vecs[17] = '{3'd7, 8'hFF, 8'hFF, 9, 16'h0001, 4'b0000};
        vecs[18] = '{3'd7, 8'hFF, 8'h01, 9, 16'hFFFF, 4'b0001};
`else
        vecs[13] = '{3'd7, 8'hFD, 8'h05, 1, 16'h0000, 4'b0110};
        vecs[14] = '{3'd7, 8'h80, 8'h80, 1, 16'h0000, 4'b0110};
        vecs[15] = '{3'd7, 8'h7F, 8'h7F, 1, 16'h0000, 4'b0110};
        vecs[16] = '{3'd7, 8'h00, 8'h85, 1, 16'h0000, 4'b0110};
        vecs[17] = '{3'd7, 8'hFF, 8'hFF, 1, 16'h0000, 4'b0110};
        vecs[18] = '{3'd7, 8'hFF, 8'h01, 1, 16'h0000, 4'b0110};
`endif

        rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {10'b0, busy, done, result, co, ovf, z, n}, 32'd0);
        rst = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_result", i), {16'b0, result}, {16'b0, vecs[i].res});
            check($sformatf("v%0d_flags", i), {28'b0, co, ovf, z, n}, {28'b0, vecs[i].flags});
        end

        // ---------------- start held high through a multiply ----------------
        @(negedge clk);
        start = 1'b1; op = 3'd7; a = 8'hFD; b = 8'h05;
        @(posedge clk); #1;
        op = 3'd0; a = 8'h01; b = 8'h01;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("held_mul_latency", lat, MUL_LAT);
        check("held_mul_result", {16'b0, result}, {16'b0, MUL_RES});
        @(posedge clk); #1;
        check("held_add_done", {31'b0, done}, 32'd1);
        check("held_add_result", {16'b0, result}, 32'h0002);
        check("held_add_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("held_done_drops", {31'b0, done}, 32'd0);

        // ---------------- reset on the 4th cycle of a multiply ----------------
        run_op(3'd0, 8'h10, 8'h22, lat);
        check("pre_reset_add", {16'b0, result}, 32'h0032);
        @(negedge clk);
        start = 1'b1; op = 3'd7; a = 8'hFD; b = 8'h05;
        @(posedge clk); #1;               // cycle 1 of the multiply
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;           // cycles 2..4
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_reset_outputs", {10'b0, busy, done, result, co, ovf, z, n}, 32'd0);
        dcount = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check("no_done_after_reset", dcount, 0);
        run_op(3'd0, 8'h02, 8'h03, lat);
        check("post_reset_latency", lat, 1);
        check("post_reset_result", {16'b0, result}, 32'h0005);
        check("post_reset_flags", {28'b0, co, ovf, z, n}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
